array_rf_sched: RTL and testbench

- Refresh scheduler and array-ownership arbiter in front of `array_refresh`.
- Generates periodic refresh demand from a programmable interval and counts owed refreshes (postponement debt).
- Arbitrates the array between the access path and refresh, pulses `array_rf_start`, and retires each refresh on `array_rf_done`.

---
 rtl/array_ctrl_pkg.sv | 15 +
 rtl/array_rf_timer.sv | 31 +++
 rtl/array_rf_sched.sv | 96 +++++++++
 tb/tb_array_rf_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_ctrl_pkg.sv
// Shared types and constants for the array control slice: scheduler FSM
// state encoding, refresh-interval width and the default postponement limit.
package array_ctrl_pkg;

  localparam int TREFI_WIDTH      = 16;
  localparam int MAX_POSTPONE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACC      = 2'd1,
    RF_START = 2'd2,
    RF_WAIT  = 2'd3
  } rf_sched_state_e;

endpackage

// File: rtl/array_rf_timer.sv
// Refresh interval timer: combinational tick when the count reaches tREFI-1,
// giving a tick period of exactly tREFI cycles; no backpressure.
module array_rf_timer
  import array_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rf_en,
  input  logic [TREFI_WIDTH-1:0] array_tREFI,
  output logic                   tick
);

  logic [TREFI_WIDTH-1:0] cnt;
  logic                   active;

  assign active = rf_en && (array_tREFI != '0);

  // >= rather than == so a shortened interval fires at once instead of wrapping
  assign tick = active && (cnt >= (array_tREFI - TREFI_WIDTH'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!active || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TREFI_WIDTH'(1);
    end
  end

endmodule

// File: rtl/array_rf_sched.sv
// Refresh scheduler and array-ownership arbiter; grant/start one cycle after the
// IDLE decision, access is never preempted (the owner releases on rf_urgent).
module array_rf_sched
  import array_ctrl_pkg::*;
#(
  parameter int MAX_POSTPONE = MAX_POSTPONE_DEF,
  parameter int DEBT_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rf_en,
  input  logic [TREFI_WIDTH-1:0] array_tREFI,
  input  logic                   acc_req,
  output logic                   acc_gnt,
  output logic                   array_rf_start,
  input  logic                   array_rf_done,
  output logic [DEBT_WIDTH-1:0]  rf_pending,
  output logic                   rf_urgent,
  output logic                   rf_overflow
);

  localparam logic [DEBT_WIDTH-1:0] DEBT_MAX = DEBT_WIDTH'(MAX_POSTPONE);

  rf_sched_state_e       state;
  logic [DEBT_WIDTH-1:0] debt;
  logic                  tick;
  logic                  done_acc;

  array_rf_timer u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .rf_en       (rf_en),
    .array_tREFI (array_tREFI),
    .tick        (tick)
  );

  assign done_acc   = (state == RF_WAIT) && array_rf_done;
  assign rf_pending = debt;
  assign rf_urgent  = (debt == DEBT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      acc_gnt        <= 1'b0;
      array_rf_start <= 1'b0;
    end else begin
      acc_gnt        <= 1'b0;
      array_rf_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rf_urgent) begin
            state          <= RF_START;
            array_rf_start <= 1'b1;
          end else if (acc_req) begin
            state   <= ACC;
            acc_gnt <= 1'b1;
          end else if (debt != '0) begin
            state          <= RF_START;
            array_rf_start <= 1'b1;
          end
        end
        ACC: begin
          if (acc_req) begin
            acc_gnt <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RF_START: state <= RF_WAIT;
        RF_WAIT: begin
          if (array_rf_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A tick and an accepted done in the same cycle cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      debt        <= '0;
      rf_overflow <= 1'b0;
    end else if (tick && !done_acc) begin
      if (debt == DEBT_MAX) begin
        rf_overflow <= 1'b1;
      end else begin
        debt <= debt + DEBT_WIDTH'(1);
      end
    end else if (!tick && done_acc) begin
      debt <= debt - DEBT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_array_rf_sched.sv
// Bench for array_rf_sched: directed scenarios plus a randomized phase, all
// checked against a cycle-level reference model and a done-after-N responder.
module tb_array_rf_sched;

  localparam int MAXP = 8;

  logic        clk;
  logic        rst_n;
  logic        rf_en;
  logic [15:0] trefi;
  logic        acc_req;
  logic        acc_gnt;
  logic        array_rf_start;
  logic        rf_done;
  logic [3:0]  rf_pending;
  logic        rf_urgent;
  logic        rf_overflow;

  int n_checks;
  int n_pass;
  int rf_n;
  int busy;
  int cyc;

  // reference model state
  int m_since;
  int m_debt;
  bit m_ovf;
  bit m_gnt;
  bit m_start;
  bit m_inref;

  array_rf_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rf_en          (rf_en),
    .array_tREFI    (trefi),
    .acc_req        (acc_req),
    .acc_gnt        (acc_gnt),
    .array_rf_start (array_rf_start),
    .array_rf_done  (rf_done),
    .rf_pending     (rf_pending),
    .rf_urgent      (rf_urgent),
    .rf_overflow    (rf_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic void model_edge();
    bit tick, done_ok, idle;
    if (!rst_n) begin
      m_since = 0; m_debt = 0; m_ovf = 0;
      m_gnt = 0; m_start = 0; m_inref = 0;
      return;
    end
    tick    = rf_en && (trefi != 0) && (m_since >= int'(trefi) - 1);
    done_ok = m_inref && !m_start && rf_done;
    idle    = !m_gnt && !m_inref;
    if (idle) begin
      if (m_debt == MAXP || (!acc_req && m_debt > 0)) begin
        m_start = 1; m_inref = 1;
      end else if (acc_req) begin
        m_gnt = 1;
      end
    end else if (m_gnt) begin
      m_gnt = acc_req;
    end else if (m_start) begin
      m_start = 0;
    end else if (rf_done) begin
      m_inref = 0;
    end
    if (tick && !done_ok) begin
      if (m_debt == MAXP) m_ovf = 1;
      else m_debt++;
    end else if (!tick && done_ok) begin
      m_debt--;
    end
    m_since = (!rf_en || trefi == 0 || tick) ? 0 : m_since + 1;
  endfunction

  task automatic step();
    logic [7:0] exp_v;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    exp_v = {m_gnt, m_start, (m_debt == MAXP), m_ovf, 4'(m_debt)};
    chk("cycle", {acc_gnt, array_rf_start, rf_urgent, rf_overflow, rf_pending}, exp_v);
    chk("ownership", acc_gnt & array_rf_start, 0);
    rf_done = 1'b0;
    if (!rst_n) begin
      busy = 0;
    end else begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) rf_done = 1'b1;
      end
      if (array_rf_start) busy = rf_n;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
  endtask

  // step until debt is gone, measuring start count and start-to-start spacing
  task automatic drain(output int starts, output int smin, output int smax);
    int last, k;
    starts = 0; smin = 1 << 30; smax = 0; last = -1; k = 0;
    while ((rf_pending != 0) && k < 2000) begin
      step();
      k++;
      if (array_rf_start) begin
        starts++;
        if (last >= 0) begin
          if (cyc - last < smin) smin = cyc - last;
          if (cyc - last > smax) smax = cyc - last;
        end
        last = cyc;
      end
    end
    chk("drain_in_bound", k < 2000, 1);
  endtask

  initial begin
    int p1, s1, starts, smin, smax, k;
    n_checks = 0; n_pass = 0; cyc = 0; busy = 0;
    rst_n = 1'b0; rf_en = 1'b0; trefi = 16'd100; acc_req = 1'b0; rf_done = 1'b0;
    rf_n = 22;

    // reset values
    do_reset();
    chk("reset_outputs", {acc_gnt, array_rf_start, rf_urgent, rf_overflow, rf_pending}, 0);

    // periodic refresh, tREFI = 100
    rf_en = 1'b1; do_reset();
    p1 = -1; s1 = -1; starts = 0;
    for (int i = 1; i <= 1050; i++) begin
      step();
      if (p1 < 0 && rf_pending == 1) p1 = i;
      if (array_rf_start) begin
        starts++;
        if (s1 < 0) s1 = i;
      end
    end
    chk("first_tick_cycle", p1, 100);
    chk("start_after_debt", s1, p1 + 1);
    chk("periodic_count", starts, 10);
    chk("periodic_drained", rf_pending, 0);

    // reset asserted while waiting for done
    k = 0;
    while (!array_rf_start && k < 200) begin step(); k++; end
    chk("reached_start", array_rf_start, 1);
    run(3);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    chk("mid_reset_outputs", {acc_gnt, array_rf_start, rf_urgent, rf_overflow, rf_pending}, 0);
    starts = 0;
    for (int i = 0; i < 100; i++) begin step(); if (array_rf_start) starts++; end
    chk("no_start_after_reset", starts, 0);

    // postponement then drain with rf_en off
    acc_req = 1'b1; rf_en = 1'b1; do_reset();
    run(850);
    chk("postpone_pending", rf_pending, MAXP);
    chk("postpone_urgent", rf_urgent, 1);
    chk("postpone_no_ovf", rf_overflow, 0);
    acc_req = 1'b0; rf_en = 1'b0;
    drain(starts, smin, smax);
    chk("drain_starts", starts, 8);
    chk("b2b_min_spacing", smin, rf_n + 2);
    chk("b2b_max_spacing", smax, rf_n + 2);
    starts = 0;
    for (int i = 0; i < 300; i++) begin step(); if (array_rf_start) starts++; end
    chk("disabled_no_starts", starts, 0);
    chk("disabled_no_debt", rf_pending, 0);

    // overflow
    acc_req = 1'b1; rf_en = 1'b1; do_reset();
    run(950);
    chk("ovf_set", rf_overflow, 1);
    chk("ovf_pending_sat", rf_pending, MAXP);
    acc_req = 1'b0; rf_en = 1'b0;
    drain(starts, smin, smax);
    chk("ovf_sticky", rf_overflow, 1);

    // arbitration: access wins when not urgent, refresh wins when urgent
    acc_req = 1'b1; rf_en = 1'b1; do_reset();
    run(250);
    acc_req = 1'b0; step();
    acc_req = 1'b1; step();
    chk("arb_acc_wins", {acc_gnt, array_rf_start, rf_pending}, {1'b1, 1'b0, 4'd2});
    rf_done = 1'b1; step();
    chk("spurious_done_acc", {acc_gnt, rf_pending}, {1'b1, 4'd2});
    run(597);
    chk("arb_urgent_pending", rf_pending, MAXP);
    acc_req = 1'b0; step();
    acc_req = 1'b1; step();
    chk("arb_rf_wins", {acc_gnt, array_rf_start}, 2'b01);
    k = 0;
    while (rf_pending == MAXP && k < 100) begin
      step(); k++;
      chk("gnt_low_during_rf", acc_gnt, 0);
    end
    step();
    chk("gnt_after_done", acc_gnt, 1);

    // tick coinciding with an accepted done
    acc_req = 1'b0; rf_en = 1'b1; rf_n = 98; do_reset();
    run(199);
    chk("coinc_before", rf_pending, 1);
    step();
    chk("coinc_unchanged", {array_rf_start, rf_pending}, {1'b0, 4'd1});
    step();
    chk("coinc_next_start", array_rf_start, 1);
    rf_n = 22;

    // spurious done in IDLE
    rf_en = 1'b0; do_reset();
    rf_done = 1'b1; step();
    run(5);
    chk("spurious_done_idle", {acc_gnt, array_rf_start, rf_pending}, 0);

    // tREFI shortened mid-count
    acc_req = 1'b1; rf_en = 1'b1; trefi = 16'd100; do_reset();
    run(50);
    chk("short_before", rf_pending, 0);
    trefi = 16'd10; step();
    chk("short_tick_next", rf_pending, 1);
    run(9);
    chk("short_period_a", rf_pending, 1);
    step();
    chk("short_period_b", rf_pending, 2);

    // randomized traffic against the model
    acc_req = 1'b0; rf_en = 1'b1; trefi = 16'd20; do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7, 0) == 0) acc_req = ~acc_req;
      if ($urandom_range(199, 0) == 0) rf_en = ~rf_en;
      if ($urandom_range(299, 0) == 0) trefi = 16'($urandom_range(40, 0));
      if ($urandom_range(49, 0) == 0) rf_done = 1'b1;
      if ($urandom_range(999, 0) == 0) rst_n = 1'b0;
      rf_n = $urandom_range(24, 1);
      step();
      rst_n = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
